// File: rtl/id_ex_if.sv
// id_ex_if: decode-to-execute handshake, operand, write-back and EX payload bundle.
interface id_ex_if #(
  parameter int A_WIDTH = 5,
  parameter int D_WIDTH = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [A_WIDTH-1:0] rs1;
  logic [A_WIDTH-1:0] rs2;
  logic [A_WIDTH-1:0] rd;
  logic [D_WIDTH-1:0] rd1_i;
  logic [D_WIDTH-1:0] rd2_i;
  logic [D_WIDTH-1:0] imm_i;
  logic [D_WIDTH-1:0] pc_i;
  logic [7:0]         ctrl_i;
  logic               wb_we;
  logic [A_WIDTH-1:0] wb_addr;
  logic [D_WIDTH-1:0] wb_data;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [D_WIDTH-1:0] ex_rd1;
  logic [D_WIDTH-1:0] ex_rd2;
  logic [D_WIDTH-1:0] ex_imm;
  logic [D_WIDTH-1:0] ex_pc;
  logic [A_WIDTH-1:0] ex_rd;
  logic [7:0]         ex_ctrl;
  logic [15:0]        bubble_cnt;
  modport master (
    output in_valid, rs1, rs2, rd, rd1_i, rd2_i, imm_i, pc_i, ctrl_i,
    output wb_we, wb_addr, wb_data, flush, out_ready,
    input  in_ready, out_valid, ex_rd1, ex_rd2, ex_imm, ex_pc, ex_rd, ex_ctrl, bubble_cnt
  );
  modport slave (
    input  in_valid, rs1, rs2, rd, rd1_i, rd2_i, imm_i, pc_i, ctrl_i,
    input  wb_we, wb_addr, wb_data, flush, out_ready,
    output in_ready, out_valid, ex_rd1, ex_rd2, ex_imm, ex_pc, ex_rd, ex_ctrl, bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble insertion and flush.
// Define ID_EX_BYPASS_EN to forward the write-back port into the captured operands.
module id_ex_stage #(
  parameter int A_WIDTH = 5,
  parameter int D_WIDTH = 32
) (
  input logic   clk,
  input logic   rst,
  id_ex_if.slave bus
);
  logic               advance;
  logic               hazard;
  logic [D_WIDTH-1:0] op1;
  logic [D_WIDTH-1:0] op2;
  assign advance = !bus.out_valid || bus.out_ready;
  assign hazard = bus.out_valid && bus.ex_ctrl[1] && bus.ex_rd != '0 && bus.in_valid &&
                  (bus.ex_rd == bus.rs1 || bus.ex_rd == bus.rs2);
  assign bus.in_ready = bus.flush || (advance && !hazard);
`ifdef ID_EX_BYPASS_EN
  // x0 wins over a (nonsensical) write-back to address 0
  always_comb begin
    op1 = bus.rs1 == '0 ? '0 : (bus.wb_we && bus.wb_addr == bus.rs1) ? bus.wb_data : bus.rd1_i;
    op2 = bus.rs2 == '0 ? '0 : (bus.wb_we && bus.wb_addr == bus.rs2) ? bus.wb_data : bus.rd2_i;
  end
`else
  always_comb begin
    op1 = bus.rs1 == '0 ? '0 : bus.rd1_i;
    op2 = bus.rs2 == '0 ? '0 : bus.rd2_i;
  end
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid  <= 1'b0;
      bus.bubble_cnt <= '0;
      bus.ex_rd1     <= '0;
      bus.ex_rd2     <= '0;
      bus.ex_imm     <= '0;
      bus.ex_pc      <= '0;
      bus.ex_rd      <= '0;
      bus.ex_ctrl    <= '0;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
    end else if (advance && hazard) begin
      bus.out_valid  <= 1'b0;
      bus.bubble_cnt <= bus.bubble_cnt == 16'hFFFF ? bus.bubble_cnt : bus.bubble_cnt + 16'd1;
    end else if (advance) begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.ex_rd1  <= op1;
        bus.ex_rd2  <= op2;
        bus.ex_imm  <= bus.imm_i;
        bus.ex_pc   <= bus.pc_i;
        bus.ex_rd   <= bus.rd;
        bus.ex_ctrl <= bus.ctrl_i;
      end
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed scenarios plus random traffic checked against a behavioural model.
module tb_id_ex_stage;
  localparam int AW = 5;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  id_ex_if #(.A_WIDTH(AW), .D_WIDTH(DW)) bus();
  id_ex_stage #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus));
  int total = 0;
  int bad = 0;
  // model of what EX currently holds
  bit            m_v;
  logic [DW-1:0] m_rd1, m_rd2, m_imm, m_pc;
  logic [AW-1:0] m_rd;
  logic [7:0]    m_ctrl;
  int            m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] src(input logic [AW-1:0] a, input logic [DW-1:0] rf);
    if (a == 0) return '0;
`ifdef ID_EX_BYPASS_EN
    if (bus.wb_we && bus.wb_addr == a) return bus.wb_data;
`endif
    return rf;
  endfunction

  task automatic model_reset();
    m_v = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_pc = 0; m_rd = 0; m_ctrl = 0; m_cnt = 0;
  endtask

  task automatic chk_outputs();
    chk("out_valid", bus.out_valid, m_v);
    chk("bubble_cnt", bus.bubble_cnt, m_cnt);
    if (m_v) begin
      chk("ex_rd1", bus.ex_rd1, m_rd1);
      chk("ex_rd2", bus.ex_rd2, m_rd2);
      chk("ex_imm", bus.ex_imm, m_imm);
      chk("ex_pc", bus.ex_pc, m_pc);
      chk("ex_rd", bus.ex_rd, m_rd);
      chk("ex_ctrl", bus.ex_ctrl, m_ctrl);
    end
  endtask

  // One clock: check in_ready from the model, apply the edge, check outputs.
  task automatic cycle();
    bit load_use, stalled, take;
    logic [DW-1:0] n1, n2;
    #1;
    load_use = m_v && m_ctrl[1] && m_rd != 0 && bus.in_valid && (m_rd == bus.rs1 || m_rd == bus.rs2);
    stalled = m_v && !bus.out_ready;
    chk("in_ready", bus.in_ready, bus.flush || (!stalled && !load_use));
    n1 = src(bus.rs1, bus.rd1_i);
    n2 = src(bus.rs2, bus.rd2_i);
    take = !bus.flush && !stalled && !load_use && bus.in_valid;
    @(posedge clk);
    #1;
    if (bus.flush) m_v = 0;
    else if (!stalled && load_use) begin
      m_v = 0;
      if (m_cnt < 65535) m_cnt++;
    end else if (!stalled) m_v = take;
    if (take) begin
      m_rd1 = n1; m_rd2 = n2; m_imm = bus.imm_i; m_pc = bus.pc_i; m_rd = bus.rd; m_ctrl = bus.ctrl_i;
    end
    chk_outputs();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_bubble_cnt"}, bus.bubble_cnt, 0);
    chk({tag, "_payload"}, (|bus.ex_rd1) | (|bus.ex_rd2) | (|bus.ex_imm) | (|bus.ex_pc) |
        (|bus.ex_rd) | (|bus.ex_ctrl), 0);
  endtask

  task automatic instr(input logic [AW-1:0] r1, input logic [AW-1:0] r2, input logic [AW-1:0] d,
                       input logic [DW-1:0] v1, input logic [DW-1:0] v2, input logic [7:0] c);
    bus.in_valid = 1; bus.rs1 = r1; bus.rs2 = r2; bus.rd = d;
    bus.rd1_i = v1; bus.rd2_i = v2; bus.ctrl_i = c;
  endtask

  initial begin
    rst = 1;
    bus.in_valid = 0; bus.rs1 = 0; bus.rs2 = 0; bus.rd = 0; bus.rd1_i = 0; bus.rd2_i = 0;
    bus.imm_i = 0; bus.pc_i = 0; bus.ctrl_i = 0; bus.wb_we = 0; bus.wb_addr = 0; bus.wb_data = 0;
    bus.flush = 0; bus.out_ready = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 0;
    // basic flow
    instr(3, 1, 9, 32'h11, 32'h22, 8'h01); bus.imm_i = 32'h4; bus.pc_i = 32'h100;
    cycle();
    chk("basic_valid", bus.out_valid, 1);
    chk("basic_rd1", bus.ex_rd1, 32'h11);
    chk("basic_imm", bus.ex_imm, 32'h4);
    // load-use: load to x5 followed by a consumer of x5
    instr(1, 2, 5, 32'h1, 32'h2, 8'h02);
    cycle();
    instr(1, 5, 6, 32'h1, 32'h55, 8'h01);
    #1;
    chk("lu_in_ready", bus.in_ready, 0);
    cycle();
    chk("lu_bubble_valid", bus.out_valid, 0);
    chk("lu_bubble_cnt", bus.bubble_cnt, 1);
    chk("lu_retry_ready", bus.in_ready, 1);
    cycle();
    chk("lu_accept", bus.out_valid, 1);
    chk("lu_rd2", bus.ex_rd2, 32'h55);
    // backpressure
    bus.out_ready = 0;
    instr(4, 0, 8, 32'h44, 32'h0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", bus.in_ready, 0);
      cycle();
      chk("bp_hold_rd2", bus.ex_rd2, 32'h55);
    end
    bus.out_ready = 1;
    cycle();
    chk("bp_capture", bus.ex_rd1, 32'h44);
    // write-back bypass
    bus.wb_we = 1; bus.wb_addr = 7; bus.wb_data = 32'hDEAD;
    instr(7, 0, 3, 32'h0, 32'h0, 8'h00);
    cycle();
`ifdef ID_EX_BYPASS_EN
    chk("bypass_rd1", bus.ex_rd1, 32'hDEAD);
`else
    chk("bypass_rd1", bus.ex_rd1, 32'h0);
`endif
    bus.wb_we = 0;
    // x0 and flush
    instr(0, 0, 2, 32'h55, 32'h66, 8'h00);
    cycle();
    chk("x0_rd1", bus.ex_rd1, 0);
    chk("x0_rd2", bus.ex_rd2, 0);
    bus.out_ready = 0; bus.flush = 1;
    cycle();
    chk("flush_valid", bus.out_valid, 0);
    bus.flush = 0; bus.out_ready = 1;
    // reset in the middle of a load-use stall
    instr(1, 2, 5, 32'h1, 32'h2, 8'h02);
    cycle();
    instr(5, 0, 6, 32'h9, 32'h0, 8'h00);
    #1;
    chk("rst_hazard_ready", bus.in_ready, 0);
    rst = 1;
    #1;
    chk_all_zero("rst_mid");
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
    #1;
    chk("rst_after_ready", bus.in_ready, 1);
    cycle();
    chk("rst_after_accept", bus.out_valid, 1);
    chk("rst_after_cnt", bus.bubble_cnt, 0);
    // random traffic on a small register set so hazards and bypasses are frequent
    for (int n = 0; n < 3000; n++) begin
      bus.in_valid = $urandom_range(0, 3) != 0;
      bus.rs1 = AW'($urandom_range(0, 7));
      bus.rs2 = AW'($urandom_range(0, 7));
      bus.rd = AW'($urandom_range(0, 7));
      bus.rd1_i = $urandom; bus.rd2_i = $urandom; bus.imm_i = $urandom; bus.pc_i = $urandom;
      bus.ctrl_i = 8'($urandom);
      bus.wb_we = $urandom_range(0, 1) == 1;
      bus.wb_addr = AW'($urandom_range(0, 7));
      bus.wb_data = $urandom;
      bus.flush = $urandom_range(0, 19) == 0;
      bus.out_ready = $urandom_range(0, 4) < 3;
      cycle();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
